dram_unpacker: RTL and testbench

- Read-side counterpart of the sampler-to-DRAM packer.
- Fetches MEM_IF_WIDTH-bit chunks of stored capture data from the memory interface and splits them into SAMPLE_PACKET_WIDTH-bit samples.
- Presents the samples, in order, on a valid/ready stream to the upload path (host/UART dump).
- Uses the same sample-number-to-address mapping and lane order as the write side, so the stored capture is reproduced exactly.

---
 rtl/dram_if_pkg.sv | 27 ++
 rtl/unpack_rd_fifo.sv | 57 +++++
 rtl/dram_unpacker.sv | 201 ++++++++++++++++++++
 tb/tb_dram_unpacker.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_if_pkg.sv
// Shared definitions for the capture DRAM packer/unpacker pair: lane and chunk
// geometry, the sample-number-to-address mapping and the unpacker FSM states.
package dram_if_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_DRAIN
   } unpack_state_t;

   function automatic int pack_size(input int mem_if_width, input int sample_width);
      return mem_if_width / sample_width;
   endfunction

   function automatic int words_per_chunk(input int mem_if_width, input int memory_word_width);
      return mem_if_width / (8 * memory_word_width);
   endfunction

   // Full-width address of the chunk holding sample_num; callers truncate to their bus width.
   function automatic logic [63:0] sample_to_adx(input logic [31:0] sample_num,
                                                 input int pack, input int wpc);
      logic [63:0] chunk;
      chunk = {32'd0, sample_num / pack[31:0]};
      return chunk * {32'd0, wpc[31:0]};
   endfunction

endpackage

// File: rtl/unpack_rd_fifo.sv
// Show-ahead FIFO for read-return chunks; head is the oldest entry, readable
// combinationally, and a push together with a pop on a full FIFO is accepted.
module unpack_rd_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             full;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CNT_W'(DEPTH));
   assign push_ok = push & (~full | pop);
   assign pop_ok  = pop & ~empty;
   assign head    = mem[rd_ptr_reg];
   assign count   = count_reg;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         count_reg <= count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

endmodule

// File: rtl/dram_unpacker.sv
// Reads stored capture chunks back from DRAM and streams them out as samples.
// Define DRAM_UNPACKER_INDEX_EN to add the sample_idx output.
module dram_unpacker
   import dram_if_pkg::*;
#(
   parameter int SAMPLE_PACKET_WIDTH = 32,
   parameter int MEM_IF_WIDTH        = 128,
   parameter int ADX_WIDTH           = 27,
   parameter int MEMORY_WORD_WIDTH   = 2,
   parameter int RD_FIFO_DEPTH       = 4
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           start,
   input  logic [31:0]                    start_sample,
   input  logic [31:0]                    num_samples,
   output logic                           busy,
   output logic                           done,
   output logic [SAMPLE_PACKET_WIDTH-1:0] sample_data,
   output logic                           sample_valid,
   input  logic                           sample_ready,
   output logic [ADX_WIDTH-1:0]           dram_adx,
   output logic                           read_req,
   input  logic                           read_allowed,
   input  logic [MEM_IF_WIDTH-1:0]        dram_rd_data,
   input  logic                           dram_rd_valid
`ifdef DRAM_UNPACKER_INDEX_EN
   ,
   output logic [31:0]                    sample_idx
`endif
);

   localparam int PACK_SIZE = pack_size(MEM_IF_WIDTH, SAMPLE_PACKET_WIDTH);
   localparam int WPC       = words_per_chunk(MEM_IF_WIDTH, MEMORY_WORD_WIDTH);
   localparam int LANE_W    = (PACK_SIZE > 1) ? $clog2(PACK_SIZE) : 1;
   localparam int CNT_W     = $clog2(RD_FIFO_DEPTH) + 1;

   unpack_state_t state_reg, state_next;
   logic [ADX_WIDTH-1:0]           adx_reg, adx_next;
   logic [31:0]                    chunks_left_reg, chunks_left_next;
   logic                           done_reg, done_next;
   logic [CNT_W-1:0]               outstanding_reg;
   logic [LANE_W-1:0]              lane_reg;
   logic [31:0]                    remain_reg;
   logic [SAMPLE_PACKET_WIDTH-1:0] sample_data_reg;
   logic                           sample_valid_reg;

   logic [LANE_W-1:0]              start_lane;
   logic [33:0]                    start_span;
   logic [31:0]                    start_chunks;
   logic [ADX_WIDTH-1:0]           start_adx;
   logic                           launch;
   logic [CNT_W:0]                 in_use;
   logic                           credit_ok;
   logic                           push;
   logic                           can_load;
   logic                           last_lane;
   logic                           pop;
   logic                           last_accept;
   logic [MEM_IF_WIDTH-1:0]        fifo_head;
   logic [CNT_W-1:0]               fifo_count;
   logic                           fifo_empty;
   logic [SAMPLE_PACKET_WIDTH-1:0] lanes [PACK_SIZE];

   // Leading lanes below the offset count toward the chunks to fetch.
   assign start_lane   = LANE_W'(start_sample % PACK_SIZE);
   assign start_span   = 34'(start_lane) + 34'(num_samples) + 34'(PACK_SIZE - 1);
   assign start_chunks = 32'(start_span / 34'(PACK_SIZE));
   assign start_adx    = ADX_WIDTH'(sample_to_adx(start_sample, PACK_SIZE, WPC));
   assign launch       = (state_reg == ST_IDLE) & start;

   // Every chunk in flight or buffered holds a FIFO slot, so returns never overflow.
   assign in_use    = {1'b0, outstanding_reg} + {1'b0, fifo_count};
   assign credit_ok = in_use < (CNT_W + 1)'(RD_FIFO_DEPTH);
   assign push      = dram_rd_valid & (state_reg != ST_IDLE) & (outstanding_reg != '0);

   for (genvar gi = 0; gi < PACK_SIZE; gi++) begin : g_lane
      assign lanes[gi] = fifo_head[gi*SAMPLE_PACKET_WIDTH +: SAMPLE_PACKET_WIDTH];
   end

   assign can_load    = (~sample_valid_reg | sample_ready) & ~fifo_empty &
                        (remain_reg != '0) & (state_reg != ST_IDLE);
   assign last_lane   = (lane_reg == LANE_W'(PACK_SIZE - 1)) | (remain_reg == 32'd1);
   assign pop         = can_load & last_lane;
   assign last_accept = (state_reg == ST_DRAIN) & sample_valid_reg & sample_ready &
                        (remain_reg == '0);

   unpack_rd_fifo #(
      .WIDTH (MEM_IF_WIDTH),
      .DEPTH (RD_FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_rd_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (push),
      .push_data (dram_rd_data),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

   always_comb begin
      state_next       = state_reg;
      adx_next         = adx_reg;
      chunks_left_next = chunks_left_reg;
      done_next        = 1'b0;
      read_req         = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               if (num_samples != '0) begin
                  state_next       = ST_REQ;
                  adx_next         = start_adx;
                  chunks_left_next = start_chunks;
               end else begin
                  done_next = 1'b1;
               end
            end
         end
         ST_REQ: begin
            read_req = read_allowed & credit_ok;
            if (read_req) begin
               adx_next         = adx_reg + ADX_WIDTH'(WPC);
               chunks_left_next = chunks_left_reg - 32'd1;
               if (chunks_left_reg == 32'd1) begin
                  state_next = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (last_accept) begin
               state_next = ST_IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg       <= ST_IDLE;
         adx_reg         <= '0;
         chunks_left_reg <= '0;
         done_reg        <= 1'b0;
         outstanding_reg <= '0;
      end else begin
         state_reg       <= state_next;
         adx_reg         <= adx_next;
         chunks_left_reg <= chunks_left_next;
         done_reg        <= done_next;
         outstanding_reg <= outstanding_reg + CNT_W'(read_req) - CNT_W'(push);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lane_reg         <= '0;
         remain_reg       <= '0;
         sample_data_reg  <= '0;
         sample_valid_reg <= 1'b0;
      end else if (launch) begin
         lane_reg   <= start_lane;
         remain_reg <= num_samples;
      end else if (can_load) begin
         sample_data_reg  <= lanes[lane_reg];
         sample_valid_reg <= 1'b1;
         lane_reg         <= last_lane ? '0 : lane_reg + LANE_W'(1);
         remain_reg       <= remain_reg - 32'd1;
      end else if (sample_valid_reg & sample_ready) begin
         sample_valid_reg <= 1'b0;
      end
   end

`ifdef DRAM_UNPACKER_INDEX_EN
   logic [31:0] next_idx_reg;
   logic [31:0] idx_reg;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         next_idx_reg <= '0;
         idx_reg      <= '0;
      end else if (launch) begin
         next_idx_reg <= start_sample;
      end else if (can_load) begin
         idx_reg      <= next_idx_reg;
         next_idx_reg <= next_idx_reg + 32'd1;
      end
   end

   assign sample_idx = idx_reg;
`endif

   assign busy         = (state_reg != ST_IDLE);
   assign done         = done_reg;
   assign dram_adx     = adx_reg;
   assign sample_data  = sample_data_reg;
   assign sample_valid = sample_valid_reg;

endmodule

// File: tb/tb_dram_unpacker.sv
// Randomized bench for dram_unpacker: a latency-modelled memory responder and an
// expected-stream model derived from sample numbers, one line per readout.
module tb_dram_unpacker;

   logic         clk = 1'b0;
   logic         resetn;
   logic         start;
   logic [31:0]  start_sample;
   logic [31:0]  num_samples;
   logic         busy;
   logic         done;
   logic [31:0]  sample_data;
   logic         sample_valid;
   logic         sample_ready;
   logic [26:0]  dram_adx;
   logic         read_req;
   logic         read_allowed;
   logic [127:0] dram_rd_data;
   logic         dram_rd_valid;
`ifdef DRAM_UNPACKER_INDEX_EN
   logic [31:0]  sample_idx;
   logic [31:0]  exp_idx_q [$];
`endif

   dram_unpacker dut (
      .clk           (clk),
      .resetn        (resetn),
      .start         (start),
      .start_sample  (start_sample),
      .num_samples   (num_samples),
      .busy          (busy),
      .done          (done),
      .sample_data   (sample_data),
      .sample_valid  (sample_valid),
      .sample_ready  (sample_ready),
      .dram_adx      (dram_adx),
      .read_req      (read_req),
      .read_allowed  (read_allowed),
      .dram_rd_data  (dram_rd_data),
      .dram_rd_valid (dram_rd_valid)
`ifdef DRAM_UNPACKER_INDEX_EN
      ,
      .sample_idx    (sample_idx)
`endif
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          rel = 0;
   int          cur_lat, allow_pct, ready_pct, ready_low_until;
   bit          allow_toggle;
   bit          quiet = 1'b0;
   logic [31:0] key = 32'h5A3C_0000;

   logic [26:0] resp_adx [$];
   int          resp_due [$];
   int          last_due = 0;
   logic [31:0] exp_q [$];
   logic [26:0] exp_adx_q [$];
   int          reads, got, last_evt, done_rel, exp_n;
   bit          done_seen, busy_at_done, held;
   logic [31:0] held_data;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] lane_val(input logic [26:0] adx, input int k);
      return ((32'(adx) << 2) | 32'(k)) ^ key;
   endfunction

   function automatic logic [127:0] mem_chunk(input logic [26:0] adx);
      logic [127:0] c;
      for (int k = 0; k < 4; k++) c[k*32 +: 32] = lane_val(adx, k);
      return c;
   endfunction

   // Address of the chunk holding a sample number: 4 samples per chunk, 8 words per chunk.
   function automatic logic [26:0] model_adx(input longint unsigned chunk);
      return 27'((chunk * 64'd8) % (64'd1 << 27));
   endfunction

   task automatic build_model(input logic [31:0] s, input logic [31:0] n);
      longint unsigned nch;
      logic [31:0] sn;
      exp_q.delete();
      exp_adx_q.delete();
`ifdef DRAM_UNPACKER_INDEX_EN
      exp_idx_q.delete();
`endif
      for (longint unsigned i = 0; i < 64'(n); i++) begin
         sn = s + 32'(i);
         exp_q.push_back(lane_val(model_adx(64'(sn / 4)), int'(sn % 4)));
`ifdef DRAM_UNPACKER_INDEX_EN
         exp_idx_q.push_back(sn);
`endif
      end
      nch = (n == 0) ? 0 : (64'(s % 4) + 64'(n) + 3) / 4;
      for (longint unsigned j = 0; j < nch; j++) exp_adx_q.push_back(model_adx(64'(s / 4) + j));
      exp_n = int'(n);
   endtask

   task automatic tick(input bit st, input logic [31:0] ss, input logic [31:0] ns);
      int due;
      start        = st;
      start_sample = ss;
      num_samples  = ns;
      read_allowed = allow_toggle ? (cyc % 2 == 0) : ($urandom_range(0, 99) < allow_pct);
      sample_ready = (rel < ready_low_until) ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
      if (resp_due.size() > 0 && resp_due[0] <= cyc) begin
         dram_rd_valid = 1'b1;
         dram_rd_data  = mem_chunk(resp_adx.pop_front());
         void'(resp_due.pop_front());
      end else begin
         dram_rd_valid = 1'b0;
         dram_rd_data  = {4{$urandom()}};
      end
      @(negedge clk);
      if (read_req) begin
         reads++;
         check_eq("req_when_allowed", 64'(read_allowed), 64'(1));
         if (exp_adx_q.size() > 0) check_eq("rd_adx", 64'(dram_adx), 64'(exp_adx_q.pop_front()));
         due = cyc + 1 + cur_lat;
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         resp_adx.push_back(dram_adx);
         resp_due.push_back(due);
      end
      if (held) begin
         check_eq("hold_valid", 64'(sample_valid), 64'(1));
         check_eq("hold_data", 64'(sample_data), 64'(held_data));
      end
      if (sample_valid && sample_ready) begin
         got++;
         last_evt = rel;
         if (exp_q.size() == 0) check_eq("sample_count", 64'(got), 64'(exp_n));
         else check_eq("sample", 64'(sample_data), 64'(exp_q.pop_front()));
`ifdef DRAM_UNPACKER_INDEX_EN
         if (exp_idx_q.size() > 0) check_eq("sample_idx", 64'(sample_idx), 64'(exp_idx_q.pop_front()));
`endif
      end
      held      = sample_valid && !sample_ready;
      held_data = sample_data;
      if (done && !done_seen) begin
         done_seen    = 1'b1;
         done_rel     = rel;
         busy_at_done = busy;
      end
      if (quiet) begin
         check_eq("quiet_valid", 64'(sample_valid), 64'(0));
         check_eq("quiet_busy", 64'(busy), 64'(0));
         check_eq("quiet_req", 64'(read_req), 64'(0));
      end
      @(posedge clk);
      #1;
      cyc++;
      rel++;
   endtask

   task automatic set_mode(input int lat, input int apct, input bit atog,
                           input int rpct, input int rlow);
      cur_lat = lat; allow_pct = apct; allow_toggle = atog;
      ready_pct = rpct; ready_low_until = rlow;
   endtask

   task automatic run(input string name, input logic [31:0] s, input logic [31:0] n,
                      input int restart_at, input int stall_at, input int stall_reads);
      int nch;
      build_model(s, n);
      nch = exp_adx_q.size();
      reads = 0; got = 0; rel = 0; last_evt = 0; done_seen = 1'b0; held = 1'b0;
      while (!done_seen && rel < 3000) begin
         if (rel == restart_at) tick(1'b1, s + 32'd100, 32'd5);
         else tick(rel == 0, s, n);
         if (rel == stall_at) check_eq("stall_reads", 64'(reads), 64'(stall_reads));
      end
      check_eq("done_seen", 64'(done_seen), 64'(1));
      if (done_seen) begin
         check_eq("done_time", 64'(done_rel), 64'(last_evt + 1));
         check_eq("busy_at_done", 64'(busy_at_done), 64'(0));
      end
      check_eq("samples", 64'(got), 64'(n));
      check_eq("reads", 64'(reads), 64'(nch));
      $display("run %-9s start=%08h n=%0d reads=%0d samples=%0d cycles=%0d",
               name, s, n, reads, got, rel);
      tick(1'b0, 32'd0, 32'd0);
      tick(1'b0, 32'd0, 32'd0);
   endtask

   initial begin
      resetn = 1'b1; start = 1'b0; start_sample = '0; num_samples = '0;
      sample_ready = 1'b0; read_allowed = 1'b0; dram_rd_data = '0; dram_rd_valid = 1'b0;
      set_mode(0, 100, 1'b0, 100, 0);
      #1 resetn = 1'b0;
      #1;
      check_eq("rst_busy", 64'(busy), 64'(0));
      check_eq("rst_done", 64'(done), 64'(0));
      check_eq("rst_valid", 64'(sample_valid), 64'(0));
      check_eq("rst_data", 64'(sample_data), 64'(0));
      check_eq("rst_req", 64'(read_req), 64'(0));
      check_eq("rst_adx", 64'(dram_adx), 64'(0));
      @(posedge clk);
      @(posedge clk);
      #1 resetn = 1'b1;

      set_mode(0, 100, 1'b0, 100, 0);
      run("basic", 32'd0, 32'd8, -1, -1, 0);
      run("offset", 32'd6, 32'd3, -1, -1, 0);
      set_mode(2, 100, 1'b0, 100, 40);
      run("stall", 32'd0, 32'd20, -1, 30, 4);
      set_mode(7, 0, 1'b1, 100, 0);
      run("toggle", 32'd3, 32'd24, -1, -1, 0);
      set_mode(1, 100, 1'b0, 100, 0);
      run("empty", 32'd77, 32'd0, -1, -1, 0);
      set_mode(3, 80, 1'b0, 70, 0);
      run("restart", 32'd10, 32'd12, 4, -1, 0);
      run("wrap", 32'hFFFF_FFFE, 32'd6, -1, -1, 0);

      // Abort with two reads in flight; their late returns must not reach the output.
      set_mode(12, 100, 1'b0, 100, 0);
      build_model(32'd0, 32'd8);
      exp_q.delete();
      exp_n = 0; reads = 0; got = 0; rel = 0; held = 1'b0;
      tick(1'b1, 32'd0, 32'd8);
      for (int i = 0; i < 3; i++) tick(1'b0, 32'd0, 32'd0);
      check_eq("abort_reads", 64'(reads), 64'(2));
      check_eq("abort_inflight", 64'(resp_due.size()), 64'(2));
      #2 resetn = 1'b0;
      #1;
      check_eq("abort_busy", 64'(busy), 64'(0));
      check_eq("abort_done", 64'(done), 64'(0));
      check_eq("abort_valid", 64'(sample_valid), 64'(0));
      check_eq("abort_data", 64'(sample_data), 64'(0));
      check_eq("abort_req", 64'(read_req), 64'(0));
      check_eq("abort_adx", 64'(dram_adx), 64'(0));
      dram_rd_valid = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      resetn = 1'b1;
      quiet = 1'b1;
      for (int i = 0; i < 16; i++) tick(1'b0, 32'd0, 32'd0);
      quiet = 1'b0;
      check_eq("stale_returned", 64'(resp_due.size()), 64'(0));
      check_eq("stale_samples", 64'(got), 64'(0));
      $display("run %-9s reads=%0d samples=%0d after reset", "abort", reads, got);

      for (int i = 0; i < 8; i++) begin
         set_mode($urandom_range(0, 9), $urandom_range(40, 100), 1'b0,
                  $urandom_range(40, 100), 0);
         run($sformatf("rand%0d", i), $urandom(), $urandom_range(1, 30), -1, -1, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
